// File: rtl/pair_merge_ctrl_pkg.sv
// Shared types and defaults for the pair-merge sequencing controller.
// The state enum lives here so that other blocks can decode the controller state.
package pair_merge_ctrl_pkg;

  localparam int unsigned W_DEF         = 8;
  localparam int unsigned NUM_PAIRS_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_LO,
    FETCH_HI,
    WRITE,
    DONE
  } state_e;

  // Pair counter width, kept at least one bit for a single-pair build.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pair_merge_ctrl_pair_accumulator.sv
// Holds the low word of a pair and registers the full-width pair sum.
// Both registers freeze while hold_i is high.
module pair_merge_ctrl_pair_accumulator
  import pair_merge_ctrl_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         hold_i,
  input  logic         load_lo_i,
  input  logic         load_sum_i,
  input  logic [W-1:0] data_a_i,
  output logic [W:0]   sum_o
);

  logic [W-1:0] lo_q;
  logic [W:0]   sum_q;

  // Sum is one bit wider than the operands, so it can never wrap.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      lo_q  <= '0;
      sum_q <= '0;
    end else if (!hold_i) begin
      if (load_lo_i) begin
        lo_q <= data_a_i;
      end
      if (load_sum_i) begin
        sum_q <= (W+1)'(lo_q) + (W+1)'(data_a_i);
      end
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/pair_merge_ctrl.sv
// Reads word pairs from memory A, writes their sums to memory B, and drives the
// increment strobes of both external address counters so they stay in lock-step.
module pair_merge_ctrl
  import pair_merge_ctrl_pkg::*;
#(
  parameter int unsigned W         = W_DEF,
  parameter int unsigned NUM_PAIRS = NUM_PAIRS_DEF
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Hold,
  input  logic [W-1:0] DataA,
  output logic         IncA,
  output logic         IncB,
  output logic         WEB,
  output logic [W:0]   DataB,
  output logic         Busy,
  output logic         Done
);

  localparam int unsigned   CW   = cnt_w(NUM_PAIRS);
  localparam logic [CW-1:0] LAST = CW'(NUM_PAIRS - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] pair_cnt_q, pair_cnt_d;
  logic          load_lo;
  logic          load_sum;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      pair_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pair_cnt_q <= pair_cnt_d;
    end
  end

  // Strobes are decoded from the state and suppressed while Hold freezes it, so a
  // held state replays its strobes once on release with the A address unchanged.
  always_comb begin
    state_d    = state_q;
    pair_cnt_d = pair_cnt_q;
    load_lo    = 1'b0;
    load_sum   = 1'b0;
    IncA       = 1'b0;
    IncB       = 1'b0;
    WEB        = 1'b0;
    Done       = 1'b0;
    if (!Hold) begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            state_d = FETCH_LO;
          end
        end
        FETCH_LO: begin
          load_lo = 1'b1;
          IncA    = 1'b1;
          state_d = FETCH_HI;
        end
        FETCH_HI: begin
          load_sum = 1'b1;
          IncA     = 1'b1;
          state_d  = WRITE;
        end
        WRITE: begin
          WEB        = 1'b1;
          IncB       = 1'b1;
          pair_cnt_d = pair_cnt_q + CW'(1);
          state_d    = (pair_cnt_q == LAST) ? DONE : FETCH_LO;
        end
        DONE: begin
          Done       = 1'b1;
          pair_cnt_d = '0;
          state_d    = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign Busy = (state_q != IDLE);

  pair_merge_ctrl_pair_accumulator #(
    .W (W)
  ) u_acc (
    .clk        (clk),
    .Reset      (Reset),
    .hold_i     (Hold),
    .load_lo_i  (load_lo),
    .load_sum_i (load_sum),
    .data_a_i   (DataA),
    .sum_o      (DataB)
  );

endmodule

// File: doc/pair_merge_ctrl.md
# pair_merge_ctrl

Sequencing controller that sits directly upstream of the B-side address counter and drives its increment input. It reads eight words from memory A at the A-counter rate, adds each consecutive pair, and writes the four sums into memory B at half that rate. It produces the increment strobes for both address counters, so the A and B addresses stay in lock-step. The counters themselves remain external, with a 3-bit A counter and a 2-bit B counter.

## Interface
Parameters:
- W, 8, data width of a memory-A word.
- NUM_PAIRS, 4, pairs per pass. Equals the depth of memory B; the B counter wraps after exactly one pass.

Ports:
- clk  in  1  clock.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle request to begin a pass. Sampled only in IDLE.
- Hold  in  1  stall. While high, the FSM and all registers freeze and IncA, IncB and WEB are forced low.
- DataA  in  W  memory-A read data. Memory A is combinational-read, so DataA is valid in the same cycle as the current A address.
- IncA  out  1  increment strobe to the A address counter.
- IncB  out  1  increment strobe to the B address counter.
- WEB  out  1  write enable for memory B, at the current B address.
- DataB  out  W+1  registered pair sum, written to memory B.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse at the end of a pass.

## Operation
- Reset values: state IDLE, lo_reg 0, DataB 0, pair_cnt 0. Outputs IncA, IncB, WEB, Busy and Done are all 0.
- States: IDLE, FETCH_LO, FETCH_HI, WRITE, DONE. Registered transitions occur only when Hold is 0.
  - IDLE: when Start=1, go to FETCH_LO. Otherwise remain.
  - FETCH_LO: lo_reg <= DataA. IncA=1. Next state FETCH_HI.
  - FETCH_HI: DataB <= {1'b0,lo_reg} + {1'b0,DataA}. IncA=1. Next state WRITE.
  - WRITE: WEB=1 and IncB=1. pair_cnt increments. If pair_cnt == NUM_PAIRS-1, go to DONE; otherwise go to FETCH_LO.
  - DONE: Done=1, pair_cnt <= 0. Next state IDLE.
- Arithmetic: the sum is unsigned and W+1 bits wide, so it never overflows. pair_cnt is $clog2(NUM_PAIRS) bits and wraps naturally.
- IncA, IncB, WEB and Done are decoded from the state and gated with ~Hold. They are never asserted in IDLE.
- Start arriving while Busy=1 is ignored and is not queued. Start in the DONE cycle is also ignored; a new pass needs Start in IDLE.
- The addresses are owned externally. After a full pass, A has advanced 8 and B has advanced 4, so both wrap to their starting values. The block does not re-zero the counters.
- Reset asserted mid-pass returns the block to IDLE immediately (asynchronously) and discards the partial pair. External counters are reset by the same Reset.
- Hold asserted in any state freezes that state. On release, the state repeats with its strobes. This makes DataA sampling safe because the A address has not moved.

## Timing
- IncA is high for 2 of every 3 busy cycles and IncB for 1 of every 3. A full pass takes 3·NUM_PAIRS + 1 cycles (13 at default) from the first FETCH_LO to the Done pulse.
- Start is sampled at edge t. FETCH_LO occupies cycle t+1 and the first WEB occurs in cycle t+3.
- DataB is registered at the end of FETCH_HI and is stable throughout WRITE. Memory B captures it on the edge that ends WRITE. The B counter advances on that same edge, so each write lands at the pre-increment address.
- Busy rises the cycle after Start is accepted and falls the cycle after Done.

## Structure
- Shared package: state enum (IDLE, FETCH_LO, FETCH_HI, WRITE, DONE) and the default constants W=8 and NUM_PAIRS=4. The enum is shared so the bench can decode the state.
- One sub-module is natural: pair_accumulator. It contains lo_reg plus the W+1-bit adder and the DataB register, with load_lo, load_sum and hold controls. The FSM stays in the top level.

## Test plan
- Reset, then Start, with memory A = 1,2,3,4,5,6,7,8 → WEB in cycles 3, 6, 9 and 12 after Start; B[0..3] = 3, 7, 11, 15; Done pulses once, 13 cycles after Start; final addresses A=0, B=0.
- A filled with 8'hFF → every B word = 9'h1FE, with no truncation.
- Hold asserted for 4 cycles in FETCH_HI of pair 1 → no strobes during Hold; the sums are unchanged; Done is delayed by exactly 4 cycles.
- Start pulsed during WRITE and again during DONE → both ignored. A single Done; the block then sits in IDLE until the next Start.
- Reset asserted during pair 2 → all outputs go to 0 immediately. Start after release → a complete, correct pass from A=0 and B=0.
- Two back-to-back passes with different A contents → the second pass overwrites B[0..3], confirming counter wrap-around.
